// File: rtl/execute_ctl_mc.sv
// Execute-stage control with a multi-cycle unit sequencer.
// It generates the operand-mux selects, the control-word write enable and the
// bubble select, and sequences a mul/div-class unit through start/done/kill.
// The sequencer stalls the pipeline upstream while the unit works and aborts
// the unit after a bounded number of busy cycles.
module execute_ctl_mc #(
  parameter int NUM_FWD    = 2,
  parameter int MC_TIMEOUT = 32,
  parameter int SEL_W      = $clog2(NUM_FWD + 2),
  parameter int CNT_W      = $clog2(MC_TIMEOUT + 2)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               stall_v_i,
  input  logic               flush_v_i,
  input  logic               instr_v_i,
  input  logic               imm_v_i,
  input  logic               pc_v_i,
  input  logic               mc_v_i,
  input  logic [NUM_FWD-1:0] rs1_fwd_hit_i,
  input  logic [NUM_FWD-1:0] rs2_fwd_hit_i,
  input  logic               mc_done_i,
  output logic               mc_start_o,
  output logic               mc_kill_o,
  output logic               stall_v_o,
  output logic               cword_w_v_o,
  output logic               cmux_sel_o,
  output logic [SEL_W-1:0]   amux_sel_o,
  output logic [SEL_W-1:0]   bmux_sel_o,
  output logic               mc_timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  // Counter value on the last permitted busy cycle. When the timeout is
  // disabled this value is never used.
  localparam logic [CNT_W-1:0] CNT_LAST = (MC_TIMEOUT == 0) ? '0 : CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic             timeout_hit;

  // Keep only the lowest-index hit: source 0 is the youngest producer.
  logic [NUM_FWD-1:0] rs1_first, rs2_first;
  logic [SEL_W-1:0]   rs1_fwd_sel, rs2_fwd_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign rs1_first[gi] = rs1_fwd_hit_i[gi];
        assign rs2_first[gi] = rs2_fwd_hit_i[gi];
      end else begin : g_upper
        assign rs1_first[gi] = rs1_fwd_hit_i[gi] & ~(|rs1_fwd_hit_i[gi-1:0]);
        assign rs2_first[gi] = rs2_fwd_hit_i[gi] & ~(|rs2_fwd_hit_i[gi-1:0]);
      end
    end
  endgenerate

  // Encode the one-hot winning source into its mux code (2 + k).
  always_comb begin
    rs1_fwd_sel = '0;
    rs2_fwd_sel = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (rs1_first[k]) rs1_fwd_sel = rs1_fwd_sel | SEL_W'(k + 2);
      if (rs2_first[k]) rs2_fwd_sel = rs2_fwd_sel | SEL_W'(k + 2);
    end
  end

  // PC and immediate override any forwarding hit on their operand.
  assign amux_sel_o = pc_v_i  ? SEL_W'(1) : ((|rs1_fwd_hit_i) ? rs1_fwd_sel : '0);
  assign bmux_sel_o = imm_v_i ? SEL_W'(1) : ((|rs2_fwd_hit_i) ? rs2_fwd_sel : '0);

  // The flag shows in the abort cycle itself and stays set until reset.
  assign mc_timeout_o = timeout_reg | timeout_hit;

  // Sequencer next state and control outputs; reset overrides everything.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    timeout_hit  = 1'b0;
    mc_start_o   = 1'b0;
    mc_kill_o    = 1'b0;
    stall_v_o    = 1'b0;
    cword_w_v_o  = ~stall_v_i;
    cmux_sel_o   = flush_v_i;

    case (state_reg)
      IDLE: begin
        if (instr_v_i && mc_v_i && !flush_v_i) begin
          mc_start_o  = 1'b1;
          stall_v_o   = 1'b1;
          cword_w_v_o = 1'b0;
          cnt_next    = '0;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        stall_v_o   = 1'b1;
        cword_w_v_o = 1'b0;
        cmux_sel_o  = 1'b1;
        // Saturate so a long wait can never wrap back onto the timeout value.
        cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        if (flush_v_i) begin
          mc_kill_o   = 1'b1;
          cword_w_v_o = ~stall_v_i;
          state_next  = IDLE;
        end else if (mc_done_i) begin
          if (!stall_v_i) begin
            cword_w_v_o = 1'b1;
            cmux_sel_o  = 1'b0;
            stall_v_o   = 1'b0;
            state_next  = IDLE;
          end else begin
            state_next = HOLD;
          end
        end else if ((MC_TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          mc_kill_o    = 1'b1;
          timeout_hit  = 1'b1;
          timeout_next = 1'b1;
          cword_w_v_o  = ~stall_v_i;
          stall_v_o    = 1'b0;
          state_next   = IDLE;
        end
      end
      HOLD: begin
        // Result sits in the unit; release on the first unstalled cycle.
        stall_v_o   = stall_v_i;
        cmux_sel_o  = 1'b0;
        cword_w_v_o = ~stall_v_i;
        if (flush_v_i) begin
          cmux_sel_o = 1'b1;
          state_next = IDLE;
        end else if (!stall_v_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!reset_n_i) begin
      mc_start_o  = 1'b0;
      mc_kill_o   = 1'b0;
      stall_v_o   = 1'b0;
      cword_w_v_o = 1'b0;
      cmux_sel_o  = 1'b1;
    end
  end

  // State, busy counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

endmodule

// File: tb/tb_execute_ctl_mc.sv
// Directed bench for execute_ctl_mc: each step drives inputs, pushes the
// expected output word to a scoreboard and compares it mid-cycle.
`timescale 1ns/1ps
module tb_execute_ctl_mc;

  localparam int NUM_FWD    = 2;
  localparam int MC_TIMEOUT = 8;
  localparam int SEL_W      = 2;

  logic               clk_i = 1'b0;
  logic               reset_n_i;
  logic               stall_v_i, flush_v_i, instr_v_i, imm_v_i, pc_v_i, mc_v_i;
  logic [NUM_FWD-1:0] rs1_fwd_hit_i, rs2_fwd_hit_i;
  logic               mc_done_i;
  logic               mc_start_o, mc_kill_o, stall_v_o, cword_w_v_o, cmux_sel_o;
  logic [SEL_W-1:0]   amux_sel_o, bmux_sel_o;
  logic               mc_timeout_o;

  execute_ctl_mc #(.NUM_FWD(NUM_FWD), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .stall_v_i(stall_v_i), .flush_v_i(flush_v_i), .instr_v_i(instr_v_i),
    .imm_v_i(imm_v_i), .pc_v_i(pc_v_i), .mc_v_i(mc_v_i),
    .rs1_fwd_hit_i(rs1_fwd_hit_i), .rs2_fwd_hit_i(rs2_fwd_hit_i),
    .mc_done_i(mc_done_i),
    .mc_start_o(mc_start_o), .mc_kill_o(mc_kill_o), .stall_v_o(stall_v_o),
    .cword_w_v_o(cword_w_v_o), .cmux_sel_o(cmux_sel_o),
    .amux_sel_o(amux_sel_o), .bmux_sel_o(bmux_sel_o),
    .mc_timeout_o(mc_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected word layout: start kill stall cword cmux amux[1:0] bmux[1:0] timeout
  function automatic logic [9:0] ev(input logic st, input logic kl, input logic sv,
                                    input logic cw, input logic cm, input logic [1:0] am,
                                    input logic [1:0] bm, input logic to);
    return {st, kl, sv, cw, cm, am, bm, to};
  endfunction

  task automatic set_in(input logic stall, input logic flush, input logic instr,
                        input logic imm, input logic pc, input logic mc,
                        input logic [1:0] h1, input logic [1:0] h2, input logic done);
    stall_v_i = stall; flush_v_i = flush; instr_v_i = instr;
    imm_v_i = imm; pc_v_i = pc; mc_v_i = mc;
    rs1_fwd_hit_i = h1; rs2_fwd_hit_i = h2; mc_done_i = done;
  endtask

  // One clock step: queue the expectation, compare at the falling edge.
  task automatic cyc(input string tag, input logic [9:0] exp_v);
    exp_t item;
    exp_t head;
    logic [9:0] obs;
    item.tag = tag;
    item.exp = exp_v;
    sb_q.push_back(item);
    @(negedge clk_i);
    head = sb_q.pop_front();
    obs = {mc_start_o, mc_kill_o, stall_v_o, cword_w_v_o, cmux_sel_o,
           amux_sel_o, bmux_sel_o, mc_timeout_o};
    checks++;
    assert (obs === head.exp)
      $display("check %-14s observed=%b expected=%b", head.tag, obs, head.exp);
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", head.tag, obs, head.exp);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0;
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    @(posedge clk_i); #1;
    cyc("reset_forced", ev(0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
    reset_n_i = 1'b1;

    // Single-cycle ops and operand selects
    set_in(0, 0, 1, 1, 0, 0, 2'b11, 2'b00, 0);
    cyc("alu_imm_fwd", ev(0, 0, 0, 1, 0, 2'd2, 2'd1, 0));
    set_in(0, 0, 1, 0, 1, 0, 2'b10, 2'b10, 0);
    cyc("alu_pc_fwd1", ev(0, 0, 0, 1, 0, 2'd1, 2'd3, 0));
    set_in(1, 1, 1, 0, 0, 0, 2'b10, 2'b01, 0);
    cyc("alu_stall_fl", ev(0, 0, 0, 0, 1, 2'd3, 2'd2, 0));
    set_in(0, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("mc_flushed", ev(0, 0, 0, 1, 1, 2'd0, 2'd0, 0));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc("idle_done_ign", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));

    // Multi-cycle op, done in the sixth busy cycle, no stall
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("mc_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
    for (int i = 1; i <= 5; i++) cyc("mc_busy", ev(0, 0, 1, 0, 1, 2'd0, 2'd0, 0));
    mc_done_i = 1'b1;
    cyc("mc_done", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("mc_after", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));

    // Done coincident with stall: HOLD until stall releases (imm stays selected)
    set_in(0, 0, 1, 1, 0, 1, 2'b00, 2'b00, 0);
    cyc("hold_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd1, 0));
    cyc("hold_busy1", ev(0, 0, 1, 0, 1, 2'd0, 2'd1, 0));
    set_in(1, 0, 1, 1, 0, 1, 2'b00, 2'b00, 1);
    cyc("hold_done_stl", ev(0, 0, 1, 0, 1, 2'd0, 2'd1, 0));
    mc_done_i = 1'b0;
    cyc("hold_1", ev(0, 0, 1, 0, 0, 2'd0, 2'd1, 0));
    cyc("hold_2", ev(0, 0, 1, 0, 0, 2'd0, 2'd1, 0));
    stall_v_i = 1'b0;
    cyc("hold_release", ev(0, 0, 0, 1, 0, 2'd0, 2'd1, 0));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("hold_after", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));

    // Flush beats done in busy cycle 2
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("fl_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
    cyc("fl_busy1", ev(0, 0, 1, 0, 1, 2'd0, 2'd0, 0));
    flush_v_i = 1'b1; mc_done_i = 1'b1;
    cyc("fl_kill", ev(0, 1, 1, 1, 1, 2'd0, 2'd0, 0));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("fl_after", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));

    // Timeout on busy cycle 8, flag sticky across a later op
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("to_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
    for (int i = 1; i <= 7; i++) cyc("to_busy", ev(0, 0, 1, 0, 1, 2'd0, 2'd0, 0));
    cyc("to_abort", ev(0, 1, 0, 1, 1, 2'd0, 2'd0, 1));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("to_idle", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 1));
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("to_op_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 1));
    mc_done_i = 1'b1;
    cyc("to_op_done", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 1));

    // Reset mid-busy: outputs forced at once, flag cleared, clean restart
    set_in(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("rst_start", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 1));
    cyc("rst_busy1", ev(0, 0, 1, 0, 1, 2'd0, 2'd0, 1));
    reset_n_i = 1'b0;
    cyc("rst_forced", ev(0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
    reset_n_i = 1'b1;
    cyc("rst_restart", ev(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
    mc_done_i = 1'b1;
    cyc("rst_done", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("rst_after", ev(0, 0, 0, 1, 0, 2'd0, 2'd0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
